regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between NUM_REQ writeback requesters, e.g. ALU, load unit and multiplier/divider. Each requester uses a valid/ready handshake. The block grants one requester per cycle using round-robin, registers the winning write, and drives the register file write controls one cycle after acceptance. It sits between the execute/memory writeback sources and the register file write port.

Parameters:
DATA_WIDTH_POW, 6, log2 of data width; width is always a power of 2
DATA_WIDTH, 1 << DATA_WIDTH_POW, writeback data width (64)
NUM_REQ, 3, number of writeback requesters (2..8)
PTR_W, $clog2(NUM_REQ), width of round-robin pointer and grant id

Ports:
clk_in  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid_in  input  NUM_REQ  per-requester write request valid
req_rd_in  input  NUM_REQ*5  per-requester destination register; slice i = bits [5i+4:5i]
req_data_in  input  NUM_REQ*DATA_WIDTH  per-requester write data; slice i = bits [DATA_WIDTH*i+DATA_WIDTH-1:DATA_WIDTH*i]
req_ready_out  input→output  NUM_REQ  one-hot grant; request i is accepted on an edge where valid[i] and ready[i] are both high
regWrite_ctrl  output  1  write enable to the register file
rd_out  output  5  destination register to the register file
writeData_out  output  DATA_WIDTH  write data to the register file
grant_id_out  output  PTR_W  index of the requester whose write is currently on the outputs
busy_out  output  1  high when any req_valid_in is high or regWrite_ctrl is high

Note: req_ready_out is an output.

Behaviour:
- Reset:
  - Synchronous, active-high reset; clock clk_in.
  - While reset is high: regWrite_ctrl=0, rd_out=0, writeData_out=0, grant_id_out=0, rr_ptr=0, req_ready_out=0.
  - Reset asserted mid-transfer discards the registered write; regWrite_ctrl=0 on the next cycle.
- Arbitration (combinational, every cycle out of reset):
  - Search order is rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - The first requester with valid=1 gets req_ready_out[i]=1. All other ready bits are 0; at most one bit is ever high.
  - If no requester is valid, req_ready_out=0.
  - req_ready_out may depend on req_valid_in. Requesters must not make valid depend on ready.
- Pointer update:
  - On an accepted transfer from requester i: rr_ptr <= (i+1) mod NUM_REQ.
  - No accept: rr_ptr holds.
  - Fairness bound: a continuously valid requester is granted within NUM_REQ cycles.
- Output stage (one register):
  - Acceptance on edge N loads rd_out, writeData_out and grant_id_out from the winning requester.
  - regWrite_ctrl is high for exactly the cycle after edge N.
  - The register file commits the write at edge N+1. Latency from accept to commit is 1 cycle.
  - The stage is never back-pressured; a new write can be accepted every cycle, giving throughput of 1 write/cycle.
  - No accept on an edge: regWrite_ctrl <= 0. rd_out, writeData_out and grant_id_out hold their previous values.
- x0 writes:
  - A request with rd=0 is still accepted and the pointer still advances.
  - regWrite_ctrl stays 0 for that slot; rd_out and writeData_out load normally.
- Ordering:
  - Same-rd requests from different requesters are serialized in grant order; the later grant's data is the final register value.
  - A single requester's writes commit in its own issue order.
- Protocol (requester obligations, checked by bench assertions):
  - Once valid[i] rises, it and that requester's rd/data slices stay stable until accepted.
  - The block holds no state per pending request.
- busy_out is purely combinational from req_valid_in and regWrite_ctrl.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, all valid=0 -> regWrite_ctrl=0, rd_out=0, req_ready_out=3'b000, grant_id_out=0, busy_out=0.
- Single write: valid[1]=1, rd=5, data=64'hDEAD_BEEF -> ready=3'b010 that cycle; next cycle regWrite_ctrl=1, rd_out=5, writeData_out=64'hDEAD_BEEF, grant_id_out=1; rr_ptr becomes 2.
- Round-robin fairness: all three valid for 6 cycles with rd=1,2,3 -> grant order 0,1,2,0,1,2; regWrite_ctrl high 6 consecutive cycles; no requester waits more than 2 cycles.
- x0 suppression: valid[0]=1, rd=0, data=64'hFFFF -> ready[0]=1; next cycle regWrite_ctrl=0, rd_out=0; rr_ptr=1.
- Same-rd conflict: req0 rd=7 data=1 and req2 rd=7 data=2 together, rr_ptr=2 -> req2 granted first, then req0; x7 final value=1 in an attached RegFile.
- Reset mid-stream: all valid, assert reset for 1 cycle after the first accept -> regWrite_ctrl=0 the following cycle, rr_ptr=0, first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback requester bundle and register-file write port
interface regfile_wb_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REQ    = 3,
    parameter int PTR_W      = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_valid_in;
    logic [NUM_REQ*5-1:0]          req_rd_in;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in;
    logic [NUM_REQ-1:0]            req_ready_out;
    logic                          regWrite_ctrl;
    logic [4:0]                    rd_out;
    logic [DATA_WIDTH-1:0]         writeData_out;
    logic [PTR_W-1:0]              grant_id_out;
    logic                          busy_out;

    modport master (
        output req_valid_in, req_rd_in, req_data_in,
        input  req_ready_out, regWrite_ctrl, rd_out, writeData_out, grant_id_out, busy_out
    );

    modport slave (
        input  req_valid_in, req_rd_in, req_data_in,
        output req_ready_out, regWrite_ctrl, rd_out, writeData_out, grant_id_out, busy_out
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter sharing the register-file write port
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH_POW = 6,
    parameter int DATA_WIDTH     = 1 << DATA_WIDTH_POW,
    parameter int NUM_REQ        = 3,
    parameter int PTR_W          = $clog2(NUM_REQ)
) (
    input  logic                clk_in,
    input  logic                reset,
    regfile_wb_arbiter_if.slave bus
);
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  regwrite_q, regwrite_d;
    logic [4:0]            rd_q, rd_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [PTR_W-1:0]      grant_id_q, grant_id_d;

    logic                  found;
    logic                  accept;
    logic [PTR_W-1:0]      win_id;
    logic [PTR_W:0]        cand;
    logic [NUM_REQ-1:0]    ready;
    logic [4:0]            win_rd;
    logic [DATA_WIDTH-1:0] win_data;

    // Scan from rr_ptr upward with wrap; the first valid requester wins.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!found && bus.req_valid_in[cand[PTR_W-1:0]]) begin
                found  = 1'b1;
                win_id = cand[PTR_W-1:0];
            end
        end
    end

    assign accept = found && !reset;

    always_comb begin
        ready    = '0;
        win_rd   = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == PTR_W'(i)) begin
                ready[i] = accept;
                win_rd   = bus.req_rd_in[5*i +: 5];
                win_data = bus.req_data_in[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    // Writes to x0 still consume a grant slot but never raise the write enable.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        regwrite_d = 1'b0;
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        grant_id_d = grant_id_q;
        if (accept) begin
            regwrite_d = (win_rd != 5'd0);
            rd_d       = win_rd;
            wdata_d    = win_data;
            grant_id_d = win_id;
            if (win_id == PTR_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = win_id + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            wdata_q    <= '0;
            grant_id_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign bus.req_ready_out = ready;
    assign bus.regWrite_ctrl = regwrite_q;
    assign bus.rd_out        = rd_q;
    assign bus.writeData_out = wdata_q;
    assign bus.grant_id_out  = grant_id_q;
    assign bus.busy_out      = (|bus.req_valid_in) || regwrite_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized and directed bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    localparam int DWP = 6;
    localparam int DW  = 64;
    localparam int N   = 3;
    localparam int PW  = 2;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_in = ~clk_in;

    regfile_wb_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(N)) bus();

    regfile_wb_arbiter #(.DATA_WIDTH_POW(DWP), .NUM_REQ(N)) dut (
        .clk_in(clk_in),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [N-1:0]  v_valid;
    logic [4:0]    v_rd   [N];
    logic [DW-1:0] v_data [N];

    int            m_ptr;
    logic          m_we;
    logic [4:0]    m_rd;
    logic [DW-1:0] m_data;
    int            m_gid;
    logic [DW-1:0] m_rf   [32];
    logic [DW-1:0] dut_rf [32];

    always @(posedge clk_in) begin
        if (bus.regWrite_ctrl) dut_rf[bus.rd_out] <= bus.writeData_out;
    end

    logic              pen = 1'b0;
    logic [N-1:0]      pv, pa;
    logic [N*5-1:0]    prd;
    logic [N*DW-1:0]   pdat;
    always @(posedge clk_in) begin
        if (pen && !reset) begin
            for (int i = 0; i < N; i++) begin
                if (pv[i] && !pa[i]) begin
                    assert (bus.req_valid_in[i] && bus.req_rd_in[5*i +: 5] == prd[5*i +: 5]
                            && bus.req_data_in[DW*i +: DW] == pdat[DW*i +: DW])
                    else $error("protocol: requester %0d changed before accept", i);
                end
            end
        end
        pv   <= bus.req_valid_in;
        pa   <= bus.req_ready_out;
        prd  <= bus.req_rd_in;
        pdat <= bus.req_data_in;
    end

    function automatic int exp_winner();
        if (reset) return -1;
        for (int k = 0; k < N; k++) begin
            if (v_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int w;
        r = '0;
        w = exp_winner();
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic drive();
        bus.req_valid_in = v_valid;
        for (int i = 0; i < N; i++) begin
            bus.req_rd_in[5*i +: 5]     = v_rd[i];
            bus.req_data_in[DW*i +: DW] = v_data[i];
        end
    endtask

    task automatic tick();
        int w;
        @(posedge clk_in);
        w = exp_winner();
        if (m_we) m_rf[m_rd] = m_data;
        if (reset) begin
            m_ptr = 0; m_we = 1'b0; m_rd = '0; m_data = '0; m_gid = 0;
        end else if (w >= 0) begin
            m_we   = (v_rd[w] != 5'd0);
            m_rd   = v_rd[w];
            m_data = v_data[w];
            m_gid  = w;
            m_ptr  = (w + 1) % N;
        end else begin
            m_we = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        reset = 1'b1; v_valid = '0; drive();
        tick(); tick();
        @(negedge clk_in);
        reset = 1'b0; drive();
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk_in);
            v_valid = '0; drive();
            tick();
        end
    endtask

    task automatic test_reset();
        @(negedge clk_in);
        reset = 1'b1; v_valid = '0;
        for (int i = 0; i < N; i++) begin v_rd[i] = 5'(i + 1); v_data[i] = 64'(i + 100); end
        drive();
        tick(); tick();
        checks++; if (bus.regWrite_ctrl !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", bus.regWrite_ctrl); end
        checks++; if (bus.rd_out !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d exp 0", bus.rd_out); end
        checks++; if (bus.writeData_out !== 64'd0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.writeData_out); end
        checks++; if (bus.grant_id_out !== 2'd0) begin errors++; $display("FAIL reset_gid got %0d exp 0", bus.grant_id_out); end
        checks++; if (bus.req_ready_out !== 3'b000) begin errors++; $display("FAIL reset_ready got %b exp 000", bus.req_ready_out); end
        checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy_out); end
        @(negedge clk_in);
        v_valid = '1; drive(); #1;
        checks++; if (bus.req_ready_out !== 3'b000) begin errors++; $display("FAIL reset_ready_valid got %b exp 000", bus.req_ready_out); end
        checks++; if (bus.busy_out !== 1'b1) begin errors++; $display("FAIL reset_busy_valid got %b exp 1", bus.busy_out); end
        tick();
        @(negedge clk_in);
        reset = 1'b0; v_valid = '0; drive();
    endtask

    task automatic test_single_write();
        do_reset();
        @(negedge clk_in);
        v_valid = 3'b010; v_rd[1] = 5'd5; v_data[1] = 64'hDEAD_BEEF; drive(); #1;
        checks++; if (bus.req_ready_out !== 3'b010) begin errors++; $display("FAIL single_ready got %b exp 010", bus.req_ready_out); end
        tick();
        checks++; if (bus.regWrite_ctrl !== 1'b1 || bus.rd_out !== 5'd5 || bus.writeData_out !== 64'hDEAD_BEEF || bus.grant_id_out !== 2'd1) begin
            errors++; $display("FAIL single_out got we=%b rd=%0d data=%h gid=%0d exp 1/5/deadbeef/1",
                               bus.regWrite_ctrl, bus.rd_out, bus.writeData_out, bus.grant_id_out);
        end
        @(negedge clk_in);
        v_valid = 3'b111; drive(); #1;
        checks++; if (bus.req_ready_out !== 3'b100) begin errors++; $display("FAIL single_ptr got %b exp 100", bus.req_ready_out); end
        tick();
        idle(1);
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_oh;
        do_reset();
        for (int i = 0; i < N; i++) begin v_rd[i] = 5'(i + 1); v_data[i] = 64'(i + 10); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_in);
            v_valid = 3'b111; drive(); #1;
            exp_oh = '0; exp_oh[c % N] = 1'b1;
            checks++; if (bus.req_ready_out !== exp_oh) begin errors++; $display("FAIL rr_ready c%0d got %b exp %b", c, bus.req_ready_out, exp_oh); end
            tick();
            checks++; if (bus.regWrite_ctrl !== 1'b1 || bus.grant_id_out !== 2'(c % N)) begin
                errors++; $display("FAIL rr_out c%0d got we=%b gid=%0d exp 1/%0d", c, bus.regWrite_ctrl, bus.grant_id_out, c % N);
            end
        end
        idle(1);
    endtask

    task automatic test_x0();
        do_reset();
        @(negedge clk_in);
        v_valid = 3'b001; v_rd[0] = 5'd0; v_data[0] = 64'hFFFF; drive(); #1;
        checks++; if (bus.req_ready_out !== 3'b001) begin errors++; $display("FAIL x0_ready got %b exp 001", bus.req_ready_out); end
        tick();
        checks++; if (bus.regWrite_ctrl !== 1'b0 || bus.rd_out !== 5'd0 || bus.writeData_out !== 64'hFFFF) begin
            errors++; $display("FAIL x0_out got we=%b rd=%0d data=%h exp 0/0/ffff", bus.regWrite_ctrl, bus.rd_out, bus.writeData_out);
        end
        @(negedge clk_in);
        v_valid = 3'b111; v_rd[0] = 5'd3; drive(); #1;
        checks++; if (bus.req_ready_out !== 3'b010) begin errors++; $display("FAIL x0_ptr got %b exp 010", bus.req_ready_out); end
        tick();
        idle(1);
    endtask

    task automatic test_same_rd();
        do_reset();
        @(negedge clk_in);
        v_valid = 3'b010; v_rd[1] = 5'd9; v_data[1] = 64'd5; drive();
        tick();
        @(negedge clk_in);
        v_valid = 3'b101; v_rd[0] = 5'd7; v_data[0] = 64'd1; v_rd[2] = 5'd7; v_data[2] = 64'd2; drive(); #1;
        checks++; if (bus.req_ready_out !== 3'b100) begin errors++; $display("FAIL samerd_first got %b exp 100", bus.req_ready_out); end
        tick();
        @(negedge clk_in);
        v_valid = 3'b001; drive(); #1;
        checks++; if (bus.req_ready_out !== 3'b001) begin errors++; $display("FAIL samerd_second got %b exp 001", bus.req_ready_out); end
        tick();
        idle(2);
        checks++; if (dut_rf[7] !== 64'd1) begin errors++; $display("FAIL samerd_x7 got %h exp 1", dut_rf[7]); end
        checks++; if (dut_rf[7] !== m_rf[7]) begin errors++; $display("FAIL samerd_model got %h exp %h", dut_rf[7], m_rf[7]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < N; i++) begin v_rd[i] = 5'(i + 1); v_data[i] = 64'(i + 20); end
        @(negedge clk_in);
        v_valid = 3'b111; drive();
        tick();
        @(negedge clk_in);
        reset = 1'b1; drive();
        tick();
        checks++; if (bus.regWrite_ctrl !== 1'b0) begin errors++; $display("FAIL midrst_we got %b exp 0", bus.regWrite_ctrl); end
        @(negedge clk_in);
        reset = 1'b0; drive(); #1;
        checks++; if (bus.req_ready_out !== 3'b001) begin errors++; $display("FAIL midrst_ready got %b exp 001", bus.req_ready_out); end
        tick();
        checks++; if (bus.grant_id_out !== 2'd0 || bus.regWrite_ctrl !== 1'b1) begin
            errors++; $display("FAIL midrst_out got gid=%0d we=%b exp 0/1", bus.grant_id_out, bus.regWrite_ctrl);
        end
        idle(1);
    endtask

    task automatic test_random();
        int wait_c [N];
        logic [N-1:0] rdy;
        do_reset();
        for (int i = 0; i < N; i++) wait_c[i] = 0;
        pen = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk_in);
            for (int i = 0; i < N; i++) begin
                if (!v_valid[i] && ($urandom % 3 != 0)) begin
                    v_valid[i] = 1'b1;
                    v_rd[i]    = 5'($urandom_range(0, 31));
                    v_data[i]  = {$urandom, $urandom};
                end
            end
            drive(); #1;
            rdy = bus.req_ready_out;
            checks++; if (rdy !== exp_ready()) begin errors++; $display("FAIL rand_ready c%0d got %b exp %b", c, rdy, exp_ready()); end
            checks++; if (bus.busy_out !== ((|v_valid) || m_we)) begin errors++; $display("FAIL rand_busy c%0d got %b", c, bus.busy_out); end
            tick();
            checks++; if (bus.regWrite_ctrl !== m_we || bus.rd_out !== m_rd || bus.writeData_out !== m_data || bus.grant_id_out !== 2'(m_gid)) begin
                errors++; $display("FAIL rand_out c%0d got we=%b rd=%0d data=%h gid=%0d exp %b/%0d/%h/%0d", c,
                                   bus.regWrite_ctrl, bus.rd_out, bus.writeData_out, bus.grant_id_out, m_we, m_rd, m_data, m_gid);
            end
            for (int i = 0; i < N; i++) begin
                if (v_valid[i]) begin
                    if (rdy[i]) begin
                        checks++; if (wait_c[i] > N - 1) begin errors++; $display("FAIL fairness req%0d waited %0d max %0d", i, wait_c[i], N - 1); end
                        wait_c[i]  = 0;
                        v_valid[i] = 1'b0;
                    end else begin
                        wait_c[i]++;
                    end
                end
            end
        end
        pen = 1'b0;
        idle(2);
        for (int r = 1; r < 32; r++) begin
            checks++; if (dut_rf[r] !== m_rf[r]) begin errors++; $display("FAIL rand_rf x%0d got %h exp %h", r, dut_rf[r], m_rf[r]); end
        end
    endtask

    initial begin
        v_valid = '0;
        for (int i = 0; i < N; i++) begin v_rd[i] = '0; v_data[i] = '0; end
        for (int r = 0; r < 32; r++) begin m_rf[r] = '0; dut_rf[r] = '0; end
        m_ptr = 0; m_we = 1'b0; m_rd = '0; m_data = '0; m_gid = 0;
        drive();
        test_reset();
        test_single_write();
        test_round_robin();
        test_x0();
        test_same_rd();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
